imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   WORD_W  - instruction word width
//   LEN_W   - width of the word-count header at the start of each stream
//   state_e - loader FSM state encoding
package imem_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StWrite
  } state_e;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: runtime writer for the instruction memory.
// Takes a byte stream (2-byte big-endian word count, then big-endian 32-bit words)
// over valid/ready and writes the words to consecutive addresses starting at BASE_ADDR.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start                 - begin a load (only honoured when idle)
//   in_byte/in_valid      - stream byte and its qualifier
//   in_ready              - a byte is accepted this cycle when in_valid is also high
//   mem_we/addr/wdata     - registered instruction-memory write port
//   busy, cpu_hold        - load in progress (cpu_hold stalls the datapath)
//   done, error           - sticky status of the last load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  // Largest legal word count: the whole memory.
  localparam longint unsigned MaxLen = 64'd1 << ADDR_W;

  state_e            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_cnt_q;
  logic [1:0]        byte_cnt_q;
  logic [WORD_W-1:0] word_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic [LEN_W-1:0]  len_full;
  logic              len_oversize;
  logic [WORD_W-1:0] word_next;
  logic [LEN_W:0]    word_cnt_inc;

  // in_ready is a pure decode of state so there is no input-to-output path.
  assign in_ready     = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData);
  assign accept       = in_valid && in_ready;
  // Length as it will be once the low byte now on the bus is taken.
  assign len_full     = {len_q[LEN_W-1 -: 8], in_byte};
  assign len_oversize = 64'(len_full) > MaxLen;
  assign word_next    = {word_q[WORD_W-9:0], in_byte};
  assign word_cnt_inc = {1'b0, word_cnt_q} + {{LEN_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StLenHi;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
          end
        end
        StLenHi: begin
          if (accept) begin
            len_q[LEN_W-1 -: 8] <= in_byte;
            state_q             <= StLenLo;
          end
        end
        StLenLo: begin
          if (accept) begin
            len_q <= len_full;
            if (len_full == '0) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else if (len_oversize) begin
              state_q <= StIdle;
              error_q <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            word_q     <= word_next;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            // Fourth byte: present the finished word to memory during WRITE.
            if (byte_cnt_q == 2'd3) begin
              state_q     <= StWrite;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt_q);
              mem_wdata_q <= word_next;
            end
          end
        end
        StWrite: begin
          word_cnt_q <= word_cnt_inc[LEN_W-1:0];
          if (word_cnt_inc == {1'b0, len_q}) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            state_q <= StData;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);
  assign cpu_hold  = busy;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (base 0 and base 254) share the
// stream inputs; expected writes and status are derived from the stream contents.
module tb_imem_loader;
  localparam int unsigned AW = 8;

  typedef logic [7:0] bytes_t [$];

  logic          clk = 1'b0;
  logic          rst;
  logic          start_a, start_b;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          rdy_a, we_a, busy_a, done_a, err_a, hold_a;
  logic          rdy_b, we_b, busy_b, done_b, err_b, hold_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [31:0]   wd_a, wd_b;

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(rdy_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
    .busy(busy_a), .done(done_a), .error(err_a), .cpu_hold(hold_a)
  );

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(254)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .busy(busy_b), .done(done_b), .error(err_b), .cpu_hold(hold_b)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor for the instance currently under test.
  int          cur = 0;
  int          busy_cnt = 0;
  logic [39:0] obs_q [$];

  always @(negedge clk) begin
    if (cur == 0 ? busy_a : busy_b) busy_cnt++;
    if (cur == 0 ? we_a : we_b) begin
      obs_q.push_back(cur == 0 ? {addr_a, wd_a} : {addr_b, wd_b});
      check_eq("rdy_low_in_write", cur == 0 ? rdy_a : rdy_b, 64'd0);
    end
  end

  function automatic logic sel(input int w, input logic a, input logic b);
    return (w == 0) ? a : b;
  endfunction

  task automatic check_reset(input int w);
    check_eq("rst_in_ready", sel(w, rdy_a, rdy_b), 0);
    check_eq("rst_mem_we", sel(w, we_a, we_b), 0);
    check_eq("rst_mem_addr", (w == 0) ? addr_a : addr_b, 0);
    check_eq("rst_mem_wdata", (w == 0) ? wd_a : wd_b, 0);
    check_eq("rst_busy", sel(w, busy_a, busy_b), 0);
    check_eq("rst_done", sel(w, done_a, done_b), 0);
    check_eq("rst_error", sel(w, err_a, err_b), 0);
    check_eq("rst_cpu_hold", sel(w, hold_a, hold_b), 0);
  endtask

  // Pulse start, then feed bytes; mode 0 = valid always, 1 = toggling, 2 = random.
  // stop_after < 0 feeds the whole stream, otherwise stops after that many accepts.
  task automatic run_load(input int w, input bytes_t bytes, input int mode, input int stop_after);
    int   idx;
    int   cyc;
    int   target;
    logic rdy;
    idx    = 0;
    cyc    = 0;
    target = (stop_after < 0) ? bytes.size() : stop_after;
    cur    = w;
    @(negedge clk);
    obs_q.delete();
    busy_cnt = 0;
    if (w == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check_eq("start_busy", sel(w, busy_a, busy_b), 1);
    check_eq("start_done_clr", sel(w, done_a, done_b), 0);
    check_eq("start_err_clr", sel(w, err_a, err_b), 0);
    check_eq("start_rdy", sel(w, rdy_a, rdy_b), 1);
    while (idx < target && cyc < 5000) begin
      in_byte = bytes[idx];
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      rdy = sel(w, rdy_a, rdy_b);
      @(negedge clk);
      if (in_valid && rdy) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("bytes_accepted", idx, target);
  endtask

  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (sel(w, busy_a, busy_b) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", sel(w, busy_a, busy_b), 0);
  endtask

  // Reference: words land at (base + i) mod 256, assembled MSB-first from the stream.
  task automatic verify(input string name, input int w, input bytes_t bytes, input int mode);
    int          len;
    int          nwords;
    int          base;
    logic [39:0] exp_w;
    logic [39:0] got_w;
    len    = {bytes[0], bytes[1]};
    nwords = (len > 256) ? 0 : len;
    base   = (w == 0) ? 0 : 254;
    check_eq({name, ".nwrites"}, obs_q.size(), nwords);
    for (int i = 0; i < nwords; i++) begin
      exp_w = {8'((base + i) % 256),
               bytes[2 + 4 * i], bytes[3 + 4 * i], bytes[4 + 4 * i], bytes[5 + 4 * i]};
      got_w = (i < obs_q.size()) ? obs_q[i] : '1;
      if (got_w !== exp_w || i == 0 || i == nwords - 1) check_eq({name, ".write"}, got_w, exp_w);
    end
    check_eq({name, ".done"}, sel(w, done_a, done_b), len <= 256);
    check_eq({name, ".error"}, sel(w, err_a, err_b), len > 256);
    check_eq({name, ".hold"}, sel(w, hold_a, hold_b), 0);
    if (mode == 0) check_eq({name, ".busy_cycles"}, busy_cnt, 2 + 5 * nwords);
  endtask

  function automatic bytes_t make_stream(input int len);
    bytes_t s;
    s.push_back(8'(len >> 8));
    s.push_back(8'(len));
    if (len <= 256) begin
      for (int i = 0; i < 4 * len; i++) s.push_back(8'($urandom));
    end
    return s;
  endfunction

  bytes_t basic;
  bytes_t s;
  int     w;
  int     len;
  int     mode;

  initial begin
    rst      = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;

    basic = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h04};

    run_load(0, basic, 0, -1);
    wait_idle(0);
    verify("basic", 0, basic, 0);
    check_eq("basic.word0", obs_q.size() > 0 ? obs_q[0] : '1, {8'd0, 32'h20080005});
    check_eq("basic.word1", obs_q.size() > 1 ? obs_q[1] : '1, {8'd1, 32'hAC090004});

    run_load(0, basic, 1, -1);
    wait_idle(0);
    verify("backpressure", 0, basic, 1);

    s = '{8'h00, 8'h00};
    run_load(0, s, 0, -1);
    wait_idle(0);
    verify("zero_len", 0, s, 0);
    // Bytes offered after completion must not be taken.
    in_byte  = 8'h00;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("zero_len.rdy_after", rdy_a, 0);
      check_eq("zero_len.idle_after", busy_a, 0);
    end
    in_valid = 1'b0;
    check_eq("zero_len.no_extra_write", obs_q.size(), 0);

    s = '{8'h01, 8'h01};
    run_load(0, s, 0, -1);
    wait_idle(0);
    verify("oversize", 0, s, 0);

    s = make_stream(3);
    run_load(1, s, 0, -1);
    wait_idle(1);
    verify("wrap", 1, s, 0);

    s = make_stream(256);
    run_load(0, s, 0, -1);
    wait_idle(0);
    verify("full_depth", 0, s, 0);

    // Reset after the 2nd data byte of word 1: only word 0 may be written.
    run_load(0, basic, 0, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset(0);
    repeat (3) @(negedge clk);
    check_eq("midrst.nwrites", obs_q.size(), 1);
    check_eq("midrst.word0", obs_q.size() > 0 ? obs_q[0] : '1, {8'd0, 32'h20080005});
    run_load(0, basic, 0, -1);
    wait_idle(0);
    verify("after_rst", 0, basic, 0);

    for (int t = 0; t < 24; t++) begin
      w    = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 2));
      case ($urandom_range(0, 7))
        0:       len = 0;
        1:       len = int'($urandom_range(257, 65535));
        default: len = int'($urandom_range(1, 6));
      endcase
      s = make_stream(len);
      run_load(w, s, mode, -1);
      wait_idle(w);
      verify("random", w, s, mode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
